// File: rtl/ans_pkg.sv
// Shared rANS definitions: reset/lower-bound state, encoder FSM encoding and
// the renormalisation upper bound used by both encoder and decoder.
package ans_pkg;

  localparam logic [31:0] RENORM_LOW = 32'h1000;

  typedef enum logic [1:0] {
    ENC_IDLE,
    ENC_RENORM,
    ENC_WAIT_UPD,
    ENC_FLUSH
  } enc_state_e;

  // 64-bit arithmetic keeps ((RENORM_LOW >> prob_bits) << word_width) * freq exact
  function automatic logic [63:0] calc_x_max(input logic [63:0] freq,
                                             input int unsigned prob_bits,
                                             input int unsigned word_width);
    logic [63:0] base;
    base = ({32'd0, RENORM_LOW} >> prob_bits) << word_width;
    return base * freq;
  endfunction

endpackage

// File: rtl/ans_word_fifo.sv
// Small output word FIFO; a push while full is dropped even if a pop happens
// in the same cycle. Head reads as zero while empty.
module ans_word_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ans_encoder_renorm.sv
// rANS encoder state holder: renormalises before each symbol, flushes at slice end.
// Optional pushed-word counter enabled by defining ANS_ENC_WORD_COUNT_EN.
module ans_encoder_renorm
  import ans_pkg::*;
#(
  parameter int STATE_WIDTH = 32,
  parameter int WORD_WIDTH  = 16,
  parameter int PROB_BITS   = 12,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sym_valid,
  output logic                   sym_ready,
  input  logic [PROB_BITS:0]     sym_freq,
  output logic [STATE_WIDTH-1:0] renorm_state,
  output logic                   renorm_state_valid,
  input  logic                   state_update,
  input  logic [STATE_WIDTH-1:0] next_state,
  input  logic                   flush_req,
  output logic                   flush_done,
  output logic [WORD_WIDTH-1:0]  bitstream_out,
  output logic                   bitstream_valid,
  input  logic                   bitstream_ready,
  output logic                   sym_err,
  output logic [31:0]            words_emitted
);
  localparam int NWORDS = STATE_WIDTH / WORD_WIDTH;
  localparam int CNTW   = $clog2(NWORDS) + 1;

  enc_state_e             r_fsm;
  enc_state_e             w_fsm_next;
  logic [STATE_WIDTH-1:0] r_state;
  logic [PROB_BITS:0]     r_freq;
  logic                   r_sym_err;
  logic [CNTW-1:0]        r_flush_cnt;
  logic                   r_flush_done;
  logic [63:0]            w_x_max;
  logic                   w_state_ge;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  logic                   w_push;
  logic                   w_shift;
  logic                   w_accept;
  logic                   w_load_upd;
  logic                   w_flush_last;

  assign w_x_max    = calc_x_max(64'(r_freq), PROB_BITS, WORD_WIDTH);
  assign w_state_ge = (64'(r_state) >= w_x_max);

  always_comb begin
    w_fsm_next   = r_fsm;
    w_push       = 1'b0;
    w_shift      = 1'b0;
    w_accept     = 1'b0;
    w_load_upd   = 1'b0;
    w_flush_last = 1'b0;
    case (r_fsm)
      ENC_IDLE: begin
        if (sym_valid) begin
          w_accept   = 1'b1;
          w_fsm_next = ENC_RENORM;
        end else if (flush_req) begin
          w_fsm_next = ENC_FLUSH;
        end
      end
      ENC_RENORM: begin
        if (!w_state_ge) begin
          w_fsm_next = ENC_WAIT_UPD;
        end else if (!w_fifo_full) begin
          w_push  = 1'b1;
          w_shift = 1'b1;
        end
      end
      ENC_WAIT_UPD: begin
        if (state_update) begin
          w_load_upd = 1'b1;
          w_fsm_next = ENC_IDLE;
        end
      end
      ENC_FLUSH: begin
        if (!w_fifo_full) begin
          w_push  = 1'b1;
          w_shift = 1'b1;
          if (r_flush_cnt == CNTW'(NWORDS - 1)) begin
            w_flush_last = 1'b1;
            w_fsm_next   = ENC_IDLE;
          end
        end
      end
      default: w_fsm_next = ENC_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm        <= ENC_IDLE;
      r_state      <= STATE_WIDTH'(RENORM_LOW);
      r_freq       <= '0;
      r_sym_err    <= 1'b0;
      r_flush_cnt  <= '0;
      r_flush_done <= 1'b0;
    end else begin
      r_fsm        <= w_fsm_next;
      r_flush_done <= w_flush_last;
      if (w_flush_last)    r_state <= STATE_WIDTH'(RENORM_LOW);
      else if (w_shift)    r_state <= r_state >> WORD_WIDTH;
      else if (w_load_upd) r_state <= next_state;
      // A zero frequency would give an empty interval; encode it as 1 and flag it
      if (w_accept) begin
        r_freq <= (sym_freq == '0) ? (PROB_BITS+1)'(1) : sym_freq;
        if (sym_freq == '0) r_sym_err <= 1'b1;
      end
      if (r_fsm != ENC_FLUSH) r_flush_cnt <= '0;
      else if (w_push)        r_flush_cnt <= r_flush_cnt + CNTW'(1);
    end
  end

  ans_word_fifo #(
    .WIDTH (WORD_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data (r_state[WORD_WIDTH-1:0]),
    .i_pop       (bitstream_ready),
    .o_head      (bitstream_out),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty)
  );

  assign sym_ready          = (r_fsm == ENC_IDLE);
  assign renorm_state       = r_state;
  assign renorm_state_valid = (r_fsm == ENC_WAIT_UPD);
  assign flush_done         = r_flush_done;
  assign bitstream_valid    = !w_fifo_empty;
  assign sym_err            = r_sym_err;

`ifdef ANS_ENC_WORD_COUNT_EN
  logic [31:0] r_words;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           r_words <= '0;
    else if (w_push && r_words != '1)  r_words <= r_words + 32'd1;
  end
  assign words_emitted = r_words;
`else
  assign words_emitted = 32'd0;
`endif

endmodule

// File: doc/ans_encoder_renorm.md
# ans_encoder_renorm

Encoder-side counterpart of the ANS decoder's range/state logic. It holds the rANS encoder state, renormalises it before each symbol by emitting low-order words into a small output FIFO, and hands the renormalised state to the encode arithmetic stage, which returns the next state. On slice end it flushes the final state into the bitstream. It sits between the symbol/frequency stage and the slice bitstream packer in the camera encode path.

## Interface
- STATE_WIDTH, 32, encoder state width
- WORD_WIDTH, 16, bitstream word width; STATE_WIDTH must be a multiple of WORD_WIDTH
- PROB_BITS, 12, probability precision (frequencies sum to 2^PROB_BITS)
- FIFO_DEPTH, 4, output word FIFO entries (power of two)

- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- sym_valid  in  1  symbol frequency offered
- sym_ready  out  1  block accepts a symbol
- sym_freq  in  PROB_BITS+1  frequency of the symbol being encoded
- renorm_state  out  STATE_WIDTH  renormalised state for the encode stage
- renorm_state_valid  out  1  renorm_state is valid, awaiting state_update
- state_update  in  1  encode stage returns next state
- next_state  in  STATE_WIDTH  encoded state
- flush_req  in  1  slice end, flush final state
- flush_done  out  1  one-cycle pulse when flush complete
- bitstream_out  out  WORD_WIDTH  FIFO head word
- bitstream_valid  out  1  FIFO not empty
- bitstream_ready  in  1  downstream consumes word
- sym_err  out  1  sticky: sym_freq==0 seen
- words_emitted  out  32  pushed-word count (see Configuration)

## Operation
- Constant RENORM_LOW = 32'h1000 (reset state; decoder lower bound).
- x_max = ((RENORM_LOW >> PROB_BITS) << WORD_WIDTH) * freq, computed in STATE_WIDTH+PROB_BITS+1 bits (no overflow). sym_freq==0 is treated as 1 and sets sym_err.
- FSM states IDLE, RENORM, WAIT_UPD, FLUSH.
- IDLE: sym_ready=1. sym_valid → latch freq, go RENORM. Otherwise flush_req → FLUSH. sym_valid has priority over simultaneous flush_req; flush_req must be held.
- RENORM: each cycle, if state >= x_max and FIFO not full: push state[WORD_WIDTH-1:0], state >>= WORD_WIDTH. If FIFO full: stall. If state < x_max: go WAIT_UPD.
- WAIT_UPD: renorm_state_valid=1, renorm_state=state. state_update → state <= next_state, go IDLE. state_update in any other state is ignored.
- FLUSH: push STATE_WIDTH/WORD_WIDTH words, least significant first, one per non-full cycle. After the last push: state <= RENORM_LOW, flush_done=1 for one cycle, go IDLE.
- FIFO push is blocked when full at the clock edge, even if a pop occurs that cycle. Pop happens on bitstream_valid && bitstream_ready. Push and pop in the same cycle is allowed when not full.

## Timing
- Reset values: state RENORM_LOW, FSM IDLE, sym_ready 1, renorm_state RENORM_LOW, renorm_state_valid 0, bitstream_valid 0, bitstream_out 0, flush_done 0, sym_err 0, words_emitted 0, FIFO empty.
- Symbol accepted at edge N. RENORM during cycle N+1. With k emitted words and no stall, renorm_state_valid asserts in cycle N+2+k.
- A pushed word is visible on bitstream_out the cycle after the push edge.
- Reset mid-operation: all state and FIFO contents are discarded immediately (asynchronous); no partial flush.

## Configuration
- ANS_ENC_WORD_COUNT_EN defined: words_emitted increments on every FIFO push, saturates at 32'hFFFFFFFF, and is cleared only by rst.
- Undefined: the counter is not built and words_emitted is tied to 0. Port list is unchanged.

## Structure
- Shared package ans_pkg holds: RENORM_LOW, the encoder FSM enum typedef, and the x_max computation function (shared with the decoder bound check).
- One sub-module: ans_word_fifo (parameterised depth/width, push/pop, full/empty, count).

## Test plan
- Reset, sym_freq=16, state 0x1000 (x_max 0x100000) → no words, renorm_state_valid two cycles after accept with renorm_state=0x1000.
- state_update next_state=0x00ABCDEF, then sym_freq=1 (x_max 0x10000) → one word 0xCDEF emitted, renorm_state=0x000000AB.
- State 0x00ABCDEF, sym_freq=0x100 → no emission, renorm_state=0x00ABCDEF.
- sym_freq=0 → sym_err stays 1 until rst; behaviour identical to freq=1.
- bitstream_ready=0 while symbols emit 5 words → bitstream_valid=1, 4 words held, FSM stalls in RENORM. Releasing ready drains words in order 1..5 with no loss.
- State 0x12345678, flush_req → words 0x5678 then 0x1234, flush_done pulse, next renorm_state=0x1000. rst asserted mid-flush → FIFO empty and bitstream_valid=0 immediately.
